// File: rtl/seg_scan_driver.sv
// Multiplexed hex display scan driver: walks a one-hot digit select, presents the
// matching nibble/decimal point, and swaps in new values only at frame boundaries.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            nib,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam bit BLANK_EN = (LZ_BLANK != 0);
  localparam logic [DIGITS-1:0] SEL0 = DIGITS'(1);

  logic [CW-1:0]         cnt_q, cnt_n;
  logic [IW-1:0]         idx_q, idx_n;
  logic [4*DIGITS-1:0]   sh_val_q, sh_val_n, d_val_q, d_val_n;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_n, d_dp_q, d_dp_n;
  logic                  pending_n;
  logic                  step, last, boundary;

  logic [3:0]            nib_n;
  logic                  dp_n;
  logic [DIGITS-1:0]     sel_n;
  logic [DIGITS-1:0]     zsuf;
  logic                  zacc;
  logic                  blank;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      d_val_q    <= '0;
      d_dp_q     <= '0;
      pending    <= 1'b0;
      nib        <= '0;
      dp         <= 1'b0;
      sel        <= SEL0;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_n;
      idx_q      <= idx_n;
      sh_val_q   <= sh_val_n;
      sh_dp_q    <= sh_dp_n;
      d_val_q    <= d_val_n;
      d_dp_q     <= d_dp_n;
      pending    <= pending_n;
      nib        <= nib_n;
      dp         <= dp_n;
      sel        <= sel_n;
      frame_tick <= boundary;
    end
  end

  // Next-state logic. The shadow always tracks the most recent load so a
  // boundary-cycle load is also re-committed correctly at the following boundary.
  always_comb begin
    step      = (cnt_q == CW'(DIV - 1));
    last      = (idx_q == IW'(DIGITS - 1));
    boundary  = step && last;
    cnt_n     = step ? '0 : cnt_q + 1'b1;
    idx_n     = idx_q;
    if (step) idx_n = last ? '0 : idx_q + 1'b1;
    sh_val_n  = load ? value : sh_val_q;
    sh_dp_n   = load ? dp_in : sh_dp_q;
    d_val_n   = d_val_q;
    d_dp_n    = d_dp_q;
    pending_n = pending;
    if (boundary) begin
      d_val_n   = load ? value : sh_val_q;
      d_dp_n    = load ? dp_in : sh_dp_q;
      pending_n = 1'b0;
    end else if (load) begin
      pending_n = 1'b1;
    end
  end

  // Output logic, evaluated on next-state index/value so outputs move with idx
  always_comb begin
    zacc  = 1'b1;
    zsuf  = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zacc = zacc && (d_val_n[4*(DIGITS-1-k) +: 4] == 4'h0);
      zsuf[DIGITS-1-k] = zacc;
    end
    blank = 1'b0;
    nib_n = '0;
    dp_n  = 1'b0;
    sel_n = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        blank    = BLANK_EN && (i != 0) && zsuf[i];
        nib_n    = d_val_n[4*i +: 4];
        dp_n     = d_dp_n[i];
        sel_n[i] = 1'b1;
      end
    end
    if (blank) begin
      nib_n = '0;
      dp_n  = 1'b0;
      sel_n = '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: one blanking and one non-blanking instance
// (DIGITS=4, DIV=4) driven in lockstep, checked against hand-computed frames.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [3:0]  nib_a, nib_b, sel_a, sel_b;
  logic        dp_a, dp_b, ft_a, ft_b, pend_a, pend_b;

  int n_cmp  = 0;
  int n_miss = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpin;
    logic [15:0] nib_a;   // expected nibble per digit, blanking instance
    logic [15:0] sel_a;   // expected sel per digit (digit i at [4i+:4])
    logic [3:0]  dp_a;    // expected dp per digit
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .nib(nib_a), .dp(dp_a), .sel(sel_a), .frame_tick(ft_a), .pending(pend_a)
  );

  seg_scan_driver #(.DIGITS(4), .DIV(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .nib(nib_b), .dp(dp_b), .sel(sel_b), .frame_tick(ft_b), .pending(pend_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ft();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ft_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_tick_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called at the negedge of cycle 0 of a frame; checks all 16 cycles.
  task automatic check_frame(input logic [15:0] en_a, input logic [15:0] es_a,
                             input logic [3:0] ed_a, input logic [15:0] en_b,
                             input logic [3:0] ed_b);
    for (int c = 0; c < 16; c++) begin
      int d = c / 4;
      chk("ft_a", {31'd0, ft_a}, {31'd0, c == 0});
      chk("ft_b", {31'd0, ft_b}, {31'd0, c == 0});
      chk("pend_a", {31'd0, pend_a}, 32'd0);
      chk("sel_a", {28'd0, sel_a}, {28'd0, es_a[4*d +: 4]});
      chk("nib_a", {28'd0, nib_a}, {28'd0, en_a[4*d +: 4]});
      chk("dp_a", {31'd0, dp_a}, {31'd0, ed_a[d]});
      chk("sel_b", {28'd0, sel_b}, {28'd0, 4'(1 << d)});
      chk("nib_b", {28'd0, nib_b}, {28'd0, en_b[4*d +: 4]});
      chk("dp_b", {31'd0, dp_b}, {31'd0, ed_b[d]});
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{16'h12AF, 4'b0100, 16'h12AF, 16'h8421, 4'b0100};
    tbl[1] = '{16'h0030, 4'b0000, 16'h0030, 16'h0021, 4'b0000};
    tbl[2] = '{16'h0000, 4'b1111, 16'h0000, 16'h0001, 4'b0001};
    tbl[3] = '{16'h0500, 4'b0001, 16'h0500, 16'h0421, 4'b0001};
    tbl[4] = '{16'hF000, 4'b1000, 16'hF000, 16'h8421, 4'b1000};

    rst = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_sel_a", {28'd0, sel_a}, 32'd1);
    chk("rst_sel_b", {28'd0, sel_b}, 32'd1);
    chk("rst_nib_a", {28'd0, nib_a}, 32'd0);
    chk("rst_dp_a", {31'd0, dp_a}, 32'd0);
    chk("rst_ft_a", {31'd0, ft_a}, 32'd0);
    chk("rst_pend_a", {31'd0, pend_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle walk after reset: digit 0 only on the blanking instance
    for (int k = 0; k < 16; k++) begin
      chk("walk_sel_a", {28'd0, sel_a}, (k < 4) ? 32'd1 : 32'd0);
      chk("walk_sel_b", {28'd0, sel_b}, {28'd0, 4'(1 << (k / 4))});
      chk("walk_nib_b", {28'd0, nib_b}, 32'd0);
      chk("walk_ft_a", {31'd0, ft_a}, 32'd0);
      @(negedge clk);
    end
    chk("first_ft_a", {31'd0, ft_a}, 32'd1);

    // Table: load mid-frame, expect it at the next frame
    for (int v = 0; v < 5; v++) begin
      wait_ft();
      repeat (5) @(negedge clk);
      load = 1'b1; value = tbl[v].value; dp_in = tbl[v].dpin;
      @(negedge clk);
      load = 1'b0;
      chk("pend_after_load", {31'd0, pend_a}, 32'd1);
      chk("no_tear_ft", {31'd0, ft_a}, 32'd0);
      wait_ft();
      check_frame(tbl[v].nib_a, tbl[v].sel_a, tbl[v].dp_a, tbl[v].value, tbl[v].dpin);
    end

    // Two loads in one frame: the last wins
    wait_ft();
    repeat (2) @(negedge clk);
    load = 1'b1; value = 16'h1111; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    chk("pend_two_loads", {31'd0, pend_a}, 32'd1);
    wait_ft();
    check_frame(16'h2222, 16'h8421, 4'b0000, 16'h2222, 4'b0000);

    // Load in the exact boundary cycle (cycle 15 of the frame)
    repeat (15) @(negedge clk);
    load = 1'b1; value = 16'hBEEF; dp_in = 4'b0010;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_ft", {31'd0, ft_a}, 32'd1);
    chk("bnd_pend", {31'd0, pend_a}, 32'd0);
    check_frame(16'hBEEF, 16'h8421, 4'b0010, 16'hBEEF, 4'b0010);
    // Still BEEF in the following frame
    check_frame(16'hBEEF, 16'h8421, 4'b0010, 16'hBEEF, 4'b0010);

    // Reset during digit 2 with a load pending
    @(negedge clk);
    load = 1'b1; value = 16'h7777; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_pend", {31'd0, pend_a}, 32'd1);
    chk("pre_rst_sel_b", {28'd0, sel_b}, 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_sel_a", {28'd0, sel_a}, 32'd1);
    chk("arst_sel_b", {28'd0, sel_b}, 32'd1);
    chk("arst_nib_a", {28'd0, nib_a}, 32'd0);
    chk("arst_nib_b", {28'd0, nib_b}, 32'd0);
    chk("arst_pend", {31'd0, pend_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ft();
    check_frame(16'h0000, 16'h0001, 4'b0000, 16'h0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
